mario_anim_ctrl: RTL and testbench

Animation sequencer and sprite-ROM address scheduler for the player sprite. It replaces the per-frame sprite ROM copies (stand, walk 1-3, jump, dead, each mirrored) with one shared 24-bit sprite ROM holding all six frames. On each video frame tick it picks the frame and facing, then generates the per-pixel ROM address. It outputs the pipelined "mario" opaque flag and pixel colour to color_mapper.

---
 rtl/mario_anim_pkg.sv | 34 +++
 rtl/mario_sprite_addr.sv | 73 +++++++
 rtl/mario_anim_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mario_anim_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mario_anim_pkg.sv
// Shared types and constants for the player-sprite animation controller.
// Holds the frame enumeration, sprite geometry defaults, the size of one
// frame image inside the shared sprite ROM, the ROM address width and the
// transparent colour key.
package mario_anim_pkg;

  localparam int          SPR_W_DEF    = 26;
  localparam int          SPR_H_DEF    = 32;
  localparam int          WALK_DIV_DEF = 4;
  localparam int          ROM_LAT_DEF  = 1;
  localparam int          FRAME_WORDS  = 832;   // SPR_W_DEF * SPR_H_DEF
  localparam int          ROM_AW       = 13;    // 6 frames * 832 words = 4992
  localparam logic [23:0] TRANSP_KEY   = 24'hFF00FF;

  // Encoding doubles as the frame's slot index in the shared ROM.
  typedef enum logic [2:0] {
    FR_STAND = 3'd0,
    FR_WALK1 = 3'd1,
    FR_WALK2 = 3'd2,
    FR_WALK3 = 3'd3,
    FR_JUMP  = 3'd4,
    FR_DEAD  = 3'd5
  } frame_e;

  // Walk cycle order: WALK1 -> WALK2 -> WALK3 -> WALK1.
  function automatic frame_e next_walk(frame_e f);
    case (f)
      FR_WALK1: next_walk = FR_WALK2;
      FR_WALK2: next_walk = FR_WALK3;
      default:  next_walk = FR_WALK1;
    endcase
  endfunction

endpackage

// File: rtl/mario_sprite_addr.sv
// Sprite ROM address generator (pipeline stage 1).
// Maps the current screen pixel into sprite-local coordinates, decides
// whether it lies inside the sprite box, applies horizontal mirroring and
// forms the shared-ROM address for the selected frame.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   draw_x_i/draw_y_i  current pixel position
//   spr_x_i/spr_y_i    sprite top-left corner (screen)
//   scroll_i           horizontal scroll offset
//   frame_i            current animation frame (frame_e encoding)
//   facing_left_i      mirror request
//   rom_addr_o         registered ROM read address
//   in_box_o           registered "pixel inside sprite" flag
module mario_sprite_addr
  import mario_anim_pkg::*;
#(
  parameter int SPR_W = SPR_W_DEF,
  parameter int SPR_H = SPR_H_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [9:0]        draw_x_i,
  input  logic [9:0]        draw_y_i,
  input  logic [9:0]        spr_x_i,
  input  logic [9:0]        spr_y_i,
  input  logic [9:0]        scroll_i,
  input  logic [2:0]        frame_i,
  input  logic              facing_left_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic              in_box_o
);

  localparam int FW = SPR_W * SPR_H;

  logic [9:0]        rel_x;
  logic [9:0]        rel_y;
  logic [9:0]        col;
  logic              in_box;
  logic [ROM_AW-1:0] base;
  logic [ROM_AW-1:0] addr_d;
  logic [ROM_AW-1:0] rom_addr_q;
  logic              in_box_q;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    // Pixels left of / above the sprite wrap to large unsigned offsets and
    // so fail the box test without any signed arithmetic.
    rel_x  = draw_x_i - spr_x_i + scroll_i;
    rel_y  = draw_y_i - spr_y_i;
    in_box = (rel_x < 10'(SPR_W)) && (rel_y < 10'(SPR_H));
    // The death pose is stored only once, so it is never mirrored.
    col    = (facing_left_i && (frame_i != FR_DEAD)) ? 10'(SPR_W - 1) - rel_x : rel_x;
    base   = ROM_AW'(frame_i) * ROM_AW'(FW);
    addr_d = in_box ? base + ROM_AW'(rel_y) * ROM_AW'(SPR_W) + ROM_AW'(col) : base;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rom_addr_q <= '0;
      in_box_q   <= 1'b0;
    end else begin
      rom_addr_q <= addr_d;
      in_box_q   <= in_box;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign in_box_o   = in_box_q;

endmodule

// File: rtl/mario_anim_ctrl.sv
// Player-sprite animation sequencer and shared sprite-ROM scheduler.
// On each frame tick (rising edge of VGA_VS) it chooses the animation frame
// and facing; per pixel it issues a ROM address, aligns the in-box flag
// with the ROM data and produces the registered opaque flag and colour.
// Ports:
//   Clk, Reset               clock, synchronous active-high reset
//   frame_clk                VGA_VS, rising edge = frame tick
//   DrawX, DrawY             current pixel
//   mario_x, mario_y         sprite top-left corner
//   process                  horizontal scroll offset
//   move_left, move_right    motion requests
//   mario_in_air, mario_alive  player status
//   rom_addr / rom_data      shared sprite ROM interface
//   frame_id, facing_left    current frame and mirror flag
//   mario, mario_pic_out     opaque flag and pixel colour for color_mapper
module mario_anim_ctrl
  import mario_anim_pkg::*;
#(
  parameter int          SPR_W    = SPR_W_DEF,
  parameter int          SPR_H    = SPR_H_DEF,
  parameter int          WALK_DIV = WALK_DIV_DEF,
  parameter logic [23:0] TRANSP   = TRANSP_KEY,
  parameter int          ROM_LAT  = ROM_LAT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        mario_x,
  input  logic [9:0]        mario_y,
  input  logic [9:0]        process,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              mario_in_air,
  input  logic              mario_alive,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [2:0]        frame_id,
  output logic              facing_left,
  output logic              mario,
  output logic [23:0]       mario_pic_out
);

  localparam int CNT_W = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;

  logic             frame_clk_q;
  logic             tick;
  frame_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             facing_q, facing_d;
  logic             in_box_s1;
  logic [ROM_LAT-1:0] box_pipe_q;
  logic             box_aligned;
  logic             opaque;
  logic             mario_q;
  logic [23:0]      pic_q;

  // ---------------- frame tick ----------------
  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_q <= 1'b0;
    else       frame_clk_q <= frame_clk;
  end

  assign tick = frame_clk & ~frame_clk_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= FR_STAND;
      cnt_q    <= '0;
      facing_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      facing_q <= facing_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    facing_d = facing_q;
    if (tick) begin
      if (!mario_alive || state_q == FR_DEAD) begin
        state_d = FR_DEAD;                    // sticky until Reset
      end else if (mario_in_air) begin
        state_d = FR_JUMP;
        cnt_d   = '0;
      end else begin
        if (move_left && !move_right) facing_d = 1'b1;
        if (move_right && !move_left) facing_d = 1'b0;
        if (move_left ^ move_right) begin
          if (state_q inside {FR_WALK1, FR_WALK2, FR_WALK3}) begin
            if (cnt_q == CNT_W'(WALK_DIV - 1)) begin
              cnt_d   = '0;
              state_d = next_walk(state_q);
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            state_d = FR_WALK1;
            cnt_d   = '0;
          end
        end else begin
          state_d = FR_STAND;
          cnt_d   = '0;
        end
      end
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    frame_id    = state_q;
    facing_left = facing_q;
  end

  // ---------------- stage 1: address generation ----------------
  mario_sprite_addr #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_addr (
    .clk_i         (Clk),
    .reset_i       (Reset),
    .draw_x_i      (DrawX),
    .draw_y_i      (DrawY),
    .spr_x_i       (mario_x),
    .spr_y_i       (mario_y),
    .scroll_i      (process),
    .frame_i       (state_q),
    .facing_left_i (facing_q),
    .rom_addr_o    (rom_addr),
    .in_box_o      (in_box_s1)
  );

  // ---------------- ROM latency alignment ----------------
  // NOTE: the alignment flags are reset so a reset mid-line drops whatever
  // was in flight instead of letting stale in-box flags reach the output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      box_pipe_q <= '0;
    end else begin
      box_pipe_q[0] <= in_box_s1;
      for (int i = 1; i < ROM_LAT; i++) box_pipe_q[i] <= box_pipe_q[i-1];
    end
  end

  assign box_aligned = box_pipe_q[ROM_LAT-1];

  // ---------------- output stage ----------------
  assign opaque = box_aligned && (rom_data != TRANSP);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mario_q <= 1'b0;
      pic_q   <= '0;
    end else begin
      mario_q <= opaque;
      pic_q   <= opaque ? rom_data : 24'h0;
    end
  end

  assign mario         = mario_q;
  assign mario_pic_out = pic_q;

endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Directed bench for mario_anim_ctrl with hand-computed expected values.
module tb_mario_anim_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_clk;
  logic [9:0]  draw_x, draw_y, spr_x, spr_y, scroll;
  logic        move_left, move_right, in_air, alive;
  logic [12:0] rom_addr;
  logic [23:0] rom_data;
  logic [2:0]  frame_id;
  logic        facing_left;
  logic        mario;
  logic [23:0] pic;

  int total = 0;
  int bad   = 0;

  int walk_exp [13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};

  always #5 clk = ~clk;

  mario_anim_ctrl dut (
    .Clk           (clk),
    .Reset         (reset),
    .frame_clk     (frame_clk),
    .DrawX         (draw_x),
    .DrawY         (draw_y),
    .mario_x       (spr_x),
    .mario_y       (spr_y),
    .process       (scroll),
    .move_left     (move_left),
    .move_right    (move_right),
    .mario_in_air  (in_air),
    .mario_alive   (alive),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .frame_id      (frame_id),
    .facing_left   (facing_left),
    .mario         (mario),
    .mario_pic_out (pic)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, landing 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One VGA_VS pulse; returns once the resulting state change has settled.
  task automatic frame_tick();
    frame_clk = 1'b1;
    step(2);
    frame_clk = 1'b0;
    step(2);
  endtask

  initial begin
    reset = 1'b1; frame_clk = 1'b0;
    draw_x = 10'd0; draw_y = 10'd0;
    spr_x = 10'd100; spr_y = 10'd200; scroll = 10'd0;
    move_left = 1'b0; move_right = 1'b0; in_air = 1'b0; alive = 1'b1;
    rom_data = 24'h123456;
    step(3);
    check("rst_frame", frame_id, 0);
    check("rst_facing", facing_left, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_mario", mario, 0);
    check("rst_pic", pic, 0);
    reset = 1'b0;

    // Idle ticks, pixel outside the sprite.
    for (int i = 0; i < 3; i++) begin
      frame_tick();
      check("idle_frame", frame_id, 0);
      check("idle_facing", facing_left, 0);
      check("idle_mario", mario, 0);
    end

    // Walk cycle with move_right held.
    move_right = 1'b1;
    for (int i = 0; i < 13; i++) begin
      frame_tick();
      check($sformatf("walk_t%0d", i + 1), frame_id, walk_exp[i]);
    end
    check("walk_facing", facing_left, 0);
    move_right = 1'b0;
    frame_tick();
    check("release_stand", frame_id, 0);

    // Address and pixel latency in STAND, facing right.
    draw_x = 10'd105; draw_y = 10'd203;
    step(1);
    check("addr_stand", rom_addr, 83);
    step(1);
    check("lat_2cyc_mario", mario, 0);
    step(1);
    check("lat_3cyc_mario", mario, 1);
    check("lat_3cyc_pic", pic, 24'h123456);

    // Turn left, then jump: mirrored JUMP frame.
    move_left = 1'b1;
    frame_tick();
    check("left_facing", facing_left, 1);
    check("left_frame", frame_id, 1);
    move_left = 1'b0; in_air = 1'b1;
    frame_tick();
    check("jump_frame", frame_id, 4);
    check("jump_facing", facing_left, 1);
    check("jump_addr", rom_addr, 3426);
    check("jump_mario", mario, 1);
    draw_x = 10'd99;
    step(3);
    check("left_of_box_mario", mario, 0);
    check("left_of_box_pic", pic, 0);
    check("left_of_box_addr", rom_addr, 3328);

    // Transparent key inside the box.
    in_air = 1'b0; draw_x = 10'd105; rom_data = 24'hFF00FF;
    step(3);
    check("transp_mario", mario, 0);
    check("transp_pic", pic, 0);

    // Both moves high: STAND, facing held (mirrored stand address).
    move_left = 1'b1; move_right = 1'b1;
    frame_tick();
    check("both_frame", frame_id, 0);
    check("both_facing", facing_left, 1);
    check("stand_mirror_addr", rom_addr, 98);
    move_left = 1'b0; move_right = 1'b0;
    rom_data = 24'h123456;

    // Death: sticky, facing held, no mirroring.
    alive = 1'b0; move_right = 1'b1;
    frame_tick();
    check("dead_frame", frame_id, 5);
    check("dead_facing", facing_left, 1);
    alive = 1'b1; in_air = 1'b1; move_right = 1'b0;
    frame_tick();
    check("dead_sticky_air", frame_id, 5);
    check("dead_addr", rom_addr, 4243);
    check("dead_mario", mario, 1);
    in_air = 1'b0;
    frame_tick();
    check("dead_sticky_idle", frame_id, 5);

    // Reset mid-line: output clears next cycle, in-flight pixels discarded.
    reset = 1'b1;
    step(1);
    check("midrst_mario", mario, 0);
    check("midrst_pic", pic, 0);
    check("midrst_frame", frame_id, 0);
    check("midrst_facing", facing_left, 0);
    check("midrst_addr", rom_addr, 0);
    reset = 1'b0;
    step(1);
    check("post_rst_1cyc_mario", mario, 0);
    step(2);
    check("post_rst_3cyc_mario", mario, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
